// File: rtl/riscv_pkg.sv
// Shared widths and the ID/EX entry layout for the operand fetch stage.
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;
    localparam int NREGS = 32;
    localparam int OP_W  = 8;

    typedef struct packed {
        logic [XLEN-1:0]  rs1_value;
        logic [XLEN-1:0]  rs2_value;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  pc;
        logic [REG_W-1:0] rd;
        logic             rd_write;
        logic             is_load;
        logic [OP_W-1:0]  op;
    } id_ex_t;

    function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_W-1:0] num);
        logic [NREGS-1:0] mask;
        mask      = '0;
        mask[num] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/operand_fetch_stage_if.sv
// Decode-side, register-file, writeback and execute-side signals of the operand fetch stage.
interface operand_fetch_stage_if;
    import riscv_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [REG_W-1:0] in_rs1;
    logic [REG_W-1:0] in_rs2;
    logic             in_uses_rs1;
    logic             in_uses_rs2;
    logic [REG_W-1:0] in_rd;
    logic             in_rd_write;
    logic             in_is_load;
    logic [XLEN-1:0]  in_imm;
    logic [XLEN-1:0]  in_pc;
    logic [OP_W-1:0]  in_op;
    logic             in_flush;
    logic [REG_W-1:0] out_rf_reg_number_1;
    logic [REG_W-1:0] out_rf_reg_number_2;
    logic [XLEN-1:0]  in_rf_value_1;
    logic [XLEN-1:0]  in_rf_value_2;
    logic             in_wb_enable;
    logic [REG_W-1:0] in_wb_number;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_rs1_value;
    logic [XLEN-1:0]  out_rs2_value;
    logic [XLEN-1:0]  out_imm;
    logic [XLEN-1:0]  out_pc;
    logic [REG_W-1:0] out_rd;
    logic             out_rd_write;
    logic             out_is_load;
    logic [OP_W-1:0]  out_op;

    // Stage side.
    modport slave (
        input  in_valid, in_rs1, in_rs2, in_uses_rs1, in_uses_rs2, in_rd, in_rd_write,
               in_is_load, in_imm, in_pc, in_op, in_flush, in_rf_value_1, in_rf_value_2,
               in_wb_enable, in_wb_number, out_ready,
        output in_ready, out_rf_reg_number_1, out_rf_reg_number_2, out_valid,
               out_rs1_value, out_rs2_value, out_imm, out_pc, out_rd, out_rd_write,
               out_is_load, out_op
    );

    // Environment side.
    modport master (
        output in_valid, in_rs1, in_rs2, in_uses_rs1, in_uses_rs2, in_rd, in_rd_write,
               in_is_load, in_imm, in_pc, in_op, in_flush, in_rf_value_1, in_rf_value_2,
               in_wb_enable, in_wb_number, out_ready,
        input  in_ready, out_rf_reg_number_1, out_rf_reg_number_2, out_valid,
               out_rs1_value, out_rs2_value, out_imm, out_pc, out_rd, out_rd_write,
               out_is_load, out_op
    );

endinterface

// File: rtl/load_scoreboard.sv
// One pending bit per register for loads handed to execute but not yet written back.
module load_scoreboard
    import riscv_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en_i,
    input  logic [REG_W-1:0] set_num_i,
    input  logic             clr_en_i,
    input  logic [REG_W-1:0] clr_num_i,
    input  logic [REG_W-1:0] q1_num_i,
    input  logic [REG_W-1:0] q2_num_i,
    input  logic [REG_W-1:0] q3_num_i,
    output logic             q1_pend_o,
    output logic             q2_pend_o,
    output logic             q3_pend_o
);

    logic [NREGS-1:0] sb_q;
    logic [NREGS-1:0] sb_d;
    logic [NREGS-1:0] set_mask_s;
    logic [NREGS-1:0] clr_mask_s;

    // Next pending vector: clear on writeback, then set on handoff so set wins.
    always_comb begin
        set_mask_s = '0;
        clr_mask_s = '0;
        if (set_en_i && (set_num_i != {REG_W{1'b0}})) begin
            set_mask_s = reg_onehot(set_num_i);
        end else begin
            set_mask_s = '0;
        end
        if (clr_en_i) begin
            clr_mask_s = reg_onehot(clr_num_i);
        end else begin
            clr_mask_s = '0;
        end
        sb_d = (sb_q & ~clr_mask_s) | set_mask_s;
    end

    // Pending vector register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    // A writeback landing this cycle is covered by the register-file bypass.
    assign q1_pend_o = sb_q[q1_num_i] && !(clr_en_i && (clr_num_i == q1_num_i));
    assign q2_pend_o = sb_q[q2_num_i] && !(clr_en_i && (clr_num_i == q2_num_i));
    assign q3_pend_o = sb_q[q3_num_i] && !(clr_en_i && (clr_num_i == q3_num_i));

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode-to-execute stage: reads operands, stalls on load hazards, holds one ID/EX entry.
module operand_fetch_stage
    import riscv_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    operand_fetch_stage_if.slave bus
);

    id_ex_t entry_q;
    id_ex_t entry_d;
    logic   out_valid_q;
    logic   out_valid_d;

    logic pend_rs1_s;
    logic pend_rs2_s;
    logic pend_rd_s;
    logic haz_rs1_s;
    logic haz_rs2_s;
    logic haz_rd_s;
    logic stall_s;
    logic ready_s;
    logic capture_s;
    logic handoff_s;
    logic sb_set_s;
    logic slot_is_load_s;

    assign bus.out_rf_reg_number_1 = bus.in_rs1;
    assign bus.out_rf_reg_number_2 = bus.in_rs2;

    load_scoreboard u_sb (
        .clk       (clk),
        .rst       (rst),
        .set_en_i  (sb_set_s),
        .set_num_i (entry_q.rd),
        .clr_en_i  (bus.in_wb_enable),
        .clr_num_i (bus.in_wb_number),
        .q1_num_i  (bus.in_rs1),
        .q2_num_i  (bus.in_rs2),
        .q3_num_i  (bus.in_rd),
        .q1_pend_o (pend_rs1_s),
        .q2_pend_o (pend_rs2_s),
        .q3_pend_o (pend_rd_s)
    );

    // The held entry is a load not yet handed off, so its result is not tracked yet.
    assign slot_is_load_s = out_valid_q && entry_q.is_load && entry_q.rd_write;

    assign haz_rs1_s = (bus.in_rs1 != {REG_W{1'b0}}) &&
                       (pend_rs1_s || (slot_is_load_s && (entry_q.rd == bus.in_rs1)));
    assign haz_rs2_s = (bus.in_rs2 != {REG_W{1'b0}}) &&
                       (pend_rs2_s || (slot_is_load_s && (entry_q.rd == bus.in_rs2)));
    assign haz_rd_s  = (bus.in_rd != {REG_W{1'b0}}) &&
                       (pend_rd_s || (slot_is_load_s && (entry_q.rd == bus.in_rd)));

    assign stall_s   = (bus.in_uses_rs1 && haz_rs1_s) ||
                       (bus.in_uses_rs2 && haz_rs2_s) ||
                       (bus.in_rd_write && haz_rd_s);
    assign ready_s   = !bus.in_flush && !stall_s && (!out_valid_q || bus.out_ready);
    assign capture_s = bus.in_valid && ready_s;
    assign handoff_s = out_valid_q && bus.out_ready;
    assign sb_set_s  = handoff_s && entry_q.is_load && entry_q.rd_write &&
                       (entry_q.rd != {REG_W{1'b0}}) && !bus.in_flush;

    assign bus.in_ready = ready_s;

    // Output register next state: flush, then capture, then drain, else hold.
    always_comb begin
        entry_d     = entry_q;
        out_valid_d = out_valid_q;
        if (bus.in_flush) begin
            out_valid_d = 1'b0;
        end else if (capture_s) begin
            entry_d.rs1_value = bus.in_rf_value_1;
            entry_d.rs2_value = bus.in_rf_value_2;
            entry_d.imm       = bus.in_imm;
            entry_d.pc        = bus.in_pc;
            entry_d.rd        = bus.in_rd;
            entry_d.rd_write  = bus.in_rd_write;
            entry_d.is_load   = bus.in_is_load;
            entry_d.op        = bus.in_op;
            out_valid_d       = 1'b1;
        end else if (handoff_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // ID/EX register.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            entry_q     <= entry_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.out_rs1_value = entry_q.rs1_value;
    assign bus.out_rs2_value = entry_q.rs2_value;
    assign bus.out_imm       = entry_q.imm;
    assign bus.out_pc        = entry_q.pc;
    assign bus.out_rd        = entry_q.rd;
    assign bus.out_rd_write  = entry_q.rd_write;
    assign bus.out_is_load   = entry_q.is_load;
    assign bus.out_op        = entry_q.op;

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Decode-to-execute pipeline stage that sits directly upstream of the 32x32 register file (two combinational read ports with write-forwarding, x0 reads as zero).
- Accepts one decoded instruction per cycle, drives the register-file read numbers, and latches the returned operands plus control into an ID/EX output register with a valid/ready handshake.
- Keeps a load scoreboard and stalls on RAW/WAW hazards against loads in flight.

Parameters:
XLEN, 32, data width of operands, immediate and PC
REG_W, 5, register number width
NREGS, 32, architectural register count (2**REG_W)
OP_W, 8, opaque decoded-operation field width, passed through unchanged

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  upstream instruction valid
in_ready  output  1  stage can accept this cycle
in_rs1, in_rs2  input  REG_W  source register numbers
in_uses_rs1, in_uses_rs2  input  1  source actually read
in_rd  input  REG_W  destination register
in_rd_write  input  1  instruction writes rd
in_is_load  input  1  instruction is a load (late writeback)
in_imm, in_pc  input  XLEN  immediate and PC, passed through
in_op  input  OP_W  decoded operation, passed through
in_flush  input  1  kill the output register and block acceptance this cycle
out_rf_reg_number_1, out_rf_reg_number_2  output  REG_W  register-file read ports (combinational = in_rs1/in_rs2)
in_rf_value_1, in_rf_value_2  input  XLEN  register-file read data (same cycle)
in_wb_enable  input  1  register-file write this cycle
in_wb_number  input  REG_W  register being written
out_valid  output  1  ID/EX entry valid
out_ready  input  1  execute stage accepts
out_rs1_value, out_rs2_value, out_imm, out_pc  output  XLEN  latched operands
out_rd  output  REG_W  latched destination
out_rd_write, out_is_load  output  1  latched control
out_op  output  OP_W  latched operation

Behaviour:
- Reset: out_valid=0; all out_* data fields=0; scoreboard=0.
- out_rf_reg_number_1/2 = in_rs1/in_rs2, combinational.
- pending(r): scoreboard bit r set, and NOT (in_wb_enable && in_wb_number==r). A same-cycle writeback is covered by the register-file bypass.
- slot_load(r): out_valid && out_is_load && out_rd_write && out_rd==r.
- haz(r): r!=0 && (pending(r) || slot_load(r)).
- stall: (in_uses_rs1 && haz(in_rs1)) || (in_uses_rs2 && haz(in_rs2)) || (in_rd_write && haz(in_rd)). The last term is the WAW check.
- in_ready = !in_flush && !stall && (!out_valid || out_ready). It is combinational and does not depend on in_valid.
- Capture when in_valid && in_ready. Latency is 1 cycle: out_* next cycle; operands are in_rf_value_* sampled at capture.
- Output register:
  - in_flush: out_valid<=0.
  - else capture: load the new entry, out_valid<=1.
  - else out_valid && out_ready: out_valid<=0.
  - else hold all out_* stable.
- Scoreboard:
  - Set bit out_rd on handoff (out_valid && out_ready && out_is_load && out_rd_write && out_rd!=0 && !in_flush).
  - Clear bit in_wb_number on in_wb_enable.
  - Same bit set and cleared in one cycle: set wins.
  - Bit 0 is never set.
- Flush does not clear the scoreboard: loads already handed off still write back.
- Reset mid-operation: the entry is dropped and all pending bits are cleared.
- A stall never corrupts a held output entry.

Decomposition:
- Shared package riscv_pkg holds XLEN, REG_W, NREGS and the id_ex_t struct (operands, imm, pc, rd, rd_write, is_load, op).
- One sub-module is natural: load_scoreboard. It holds the NREGS-bit vector with set/clear ports and a pending query for three register numbers.

Test Plan:
- Reset, then in_valid=1 with rs1=3, rs2=4, rf values 0x11/0x22, imm=0x5 -> next cycle out_valid=1, out_rs1_value=0x11, out_rs2_value=0x22, out_imm=0x5.
- Load rd=7 accepted downstream, then an instruction using rs1=7 -> in_ready=0 each cycle until in_wb_enable with in_wb_number=7. In that wb cycle in_ready=1 and the capture uses the forwarded value.
- Load rd=7 sitting in the output with out_ready=0, dependent instruction presented -> no capture. Raise out_ready -> handoff sets bit 7 and the dependent instruction still stalls.
- out_ready=0 for 3 cycles with out_valid=1 -> all out_* stable and in_ready=0. Then out_ready=1 with a new in_valid -> back-to-back handoff and capture in one cycle.
- in_flush while out_valid=1 and in_valid=1 -> next cycle out_valid=0, nothing captured, scoreboard bits unchanged.
- Load with rd=0, then an instruction using rs1=0 -> no stall and no scoreboard bit set. Separately, a load to rd=9 while bit 9 is pending -> WAW stall until the writeback to 9.
